pulse_stretch_moore: RTL and testbench

PULSE_STRETCH_MOORE -- requirements
Module: pulse_stretch_moore

---
 rtl/pulse_stretch_moore.sv | 144 ++++++++++++++
 tb/tb_pulse_stretch_moore.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_moore.sv
// -----------------------------------------------------------------------------
// pulse_stretch_moore
//
// Purpose
//    Stretches a single-cycle trigger tick into a level pulse of programmable
//    length, followed by a fixed number of forced-low "gap" cycles. Implemented
//    as a three-state Moore machine (IDLE -> HIGH -> GAP -> IDLE), so out, busy
//    and dbg_state come straight from the state register. done is a registered
//    tick marking the first GAP cycle.
//
//    Timing: a trig sampled on rising edge k gives out=1 in cycles k+1..k+L,
//    where L = len, or 1 when len = 0. done is high in cycle k+L+1 and the
//    machine is back in IDLE in cycle k+L+GAP_LEN+1.
//
//    Retriggerable mode (retrig=1): a trig while HIGH reloads the length
//    counter with the current len, extending the pulse. The reload wins over
//    an expiry in the same cycle, so the pulse never has a hole.
//    Non-retriggerable mode (retrig=0): trig and len are ignored while HIGH.
//    In GAP, trig is ignored in both modes.
//
// Parameters
//    CNT_W    width of len and of the internal length counter
//    GAP_LEN  number of forced-low cycles after each pulse (1..255)
//
// Ports
//    clk        in   clock, all state changes on its rising edge
//    rst        in   asynchronous, active-high reset
//    trig       in   single-cycle trigger tick
//    len        in   requested pulse length in cycles (0 treated as 1)
//    retrig     in   1 = retriggerable, 0 = non-retriggerable
//    out        out  stretched pulse
//    busy       out  high whenever the machine is not IDLE
//    done       out  one-cycle tick in the first GAP cycle
//    dbg_state  out  raw state encoding
// -----------------------------------------------------------------------------
module pulse_stretch_moore #(
   parameter int CNT_W   = 8,
   parameter int GAP_LEN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic [CNT_W-1:0] len,
   input  logic             retrig,
   output logic             out,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HIGH    = 2'b01,
      GAP     = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   // Gap counter is 8 bits wide because GAP_LEN is limited to 255.
   localparam logic [7:0] GAP_LOAD = 8'(GAP_LEN - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic [7:0]       gap_reg,   gap_next;
   logic             done_reg,  done_next;

   // Counter load value L-1; len=0 is treated as L=1, which also loads 0.
   logic [CNT_W-1:0] len_load;

   assign len_load = (len == '0) ? '0 : (len - {{(CNT_W-1){1'b0}}, 1'b1});

   // -------------------------------------------------------------------------
   // State register. The asynchronous reset takes the state back to IDLE
   // immediately, which drops out/busy without waiting for a clock edge.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         gap_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         gap_reg   <= gap_next;
         done_reg  <= done_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and counter logic.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      gap_next   = gap_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (trig) begin
               state_next = HIGH;
               cnt_next   = len_load;
            end
         end

         HIGH: begin
            if (retrig && trig) begin
               // Reload has priority over expiry so the pulse stays contiguous.
               cnt_next = len_load;
            end else if (cnt_reg == '0) begin
               state_next = GAP;
               gap_next   = GAP_LOAD;
               // Registered, so done is high exactly in the first GAP cycle.
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end

         GAP: begin
            if (gap_reg == 8'd0) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_reg - 8'd1;
            end
         end

         default: begin
            // Unreachable encoding: recover to IDLE on the next edge.
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Moore outputs: decoded from the registered state only. The illegal
   // encoding gives out=0 and busy=1 for its single cycle.
   // -------------------------------------------------------------------------
   assign out       = (state_reg == HIGH);
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign dbg_state = state_reg;

endmodule

// File: tb/tb_pulse_stretch_moore.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_moore
//
// Self-checking bench for pulse_stretch_moore (CNT_W=8, GAP_LEN=2).
// Cycle n is the interval after rising edge n; inputs driven during cycle n
// are sampled at edge n+1. The reference model keeps two timestamps: the last
// out-high cycle and the last busy cycle of the current pulse, and derives
// every output from them.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_moore;

   localparam int CNT_W   = 8;
   localparam int GAP_LEN = 2;
   localparam int HIST_N  = 2048;

   logic             clk = 1'b0;
   logic             rst;
   logic             trig;
   logic [CNT_W-1:0] len;
   logic             retrig;
   logic             out;
   logic             busy;
   logic             done;
   logic [1:0]       dbg_state;

   pulse_stretch_moore #(
      .CNT_W   (CNT_W),
      .GAP_LEN (GAP_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trig      (trig),
      .len       (len),
      .retrig    (retrig),
      .out       (out),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int t        = 0;          // current cycle index
   int high_until = -5;       // model: last cycle with out=1
   int gap_until  = -5;       // model: last cycle with busy=1
   logic [4:0] hist [0:HIST_N-1];  // observed {out,busy,done,dbg_state}

   typedef struct {
      logic             trig;
      logic [CNT_W-1:0] len;
      logic             retrig;
      logic [4:0]       exp;    // {out,busy,done,dbg_state} in this cycle
   } vec_t;

   vec_t vecs [11];

   function automatic logic [4:0] observed();
      return {out, busy, done, dbg_state};
   endfunction

   function automatic logic [4:0] predict(int c);
      logic       o, b, d;
      logic [1:0] s;
      o = (c <= high_until);
      b = (c <= gap_until);
      d = (c == high_until + 1);
      s = o ? 2'b01 : (b ? 2'b10 : 2'b00);
      return {o, b, d, s};
   endfunction

   function automatic int count_bit(int pos, int from, int to);
      int n = 0;
      for (int i = from; i <= to; i++)
         if (i >= 0 && i < HIST_N) n += int'(hist[i][pos]);
      return n;
   endfunction

   task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d out/busy/done/state got=%b required=%b", name, t, act, exp);
      end else begin
         $display("ok   %s cycle=%0d out/busy/done/state=%b", name, t, act);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, act, exp);
      end else begin
         $display("ok   %s value=%0d", name, act);
      end
   endtask

   // One cycle: record and check outputs of cycle t, drive inputs for cycle t,
   // update the model with what the next edge will do, advance to cycle t+1.
   task automatic tick(input logic tr, input logic [CNT_W-1:0] ln, input logic rt);
      int l;
      if (t < HIST_N) hist[t] = observed();
      check5("model", observed(), predict(t));
      trig   = tr;
      len    = ln;
      retrig = rt;
      l = (ln == 0) ? 1 : int'(ln);
      if (tr && ((t > gap_until) || (rt && (t <= high_until)))) begin
         high_until = t + l;
         gap_until  = t + l + GAP_LEN;
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached at cycle=%0d", t);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;

      // Basic pulse len=3, then zero-length pulse.
      vecs[0]  = '{1'b1, 8'd3, 1'b0, 5'b00000};
      vecs[1]  = '{1'b0, 8'd3, 1'b0, 5'b11001};
      vecs[2]  = '{1'b0, 8'd3, 1'b0, 5'b11001};
      vecs[3]  = '{1'b0, 8'd3, 1'b0, 5'b11001};
      vecs[4]  = '{1'b0, 8'd3, 1'b0, 5'b01110};
      vecs[5]  = '{1'b0, 8'd3, 1'b0, 5'b01010};
      vecs[6]  = '{1'b1, 8'd0, 1'b0, 5'b00000};
      vecs[7]  = '{1'b0, 8'd0, 1'b0, 5'b11001};
      vecs[8]  = '{1'b0, 8'd0, 1'b0, 5'b01110};
      vecs[9]  = '{1'b0, 8'd0, 1'b0, 5'b01010};
      vecs[10] = '{1'b0, 8'd0, 1'b0, 5'b00000};

      rst    = 1'b1;
      trig   = 1'b0;
      len    = '0;
      retrig = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check5("reset_state", observed(), 5'b00000);
      rst = 1'b0;
      t   = 0;

      // Table-driven vectors.
      for (int i = 0; i < 11; i++) begin
         check5($sformatf("vec%0d", i), observed(), vecs[i].exp);
         tick(vecs[i].trig, vecs[i].len, vecs[i].retrig);
      end

      // Retriggerable: len=4, trig in cycles 0 and 3.
      b = t;
      tick(1'b1, 8'd4, 1'b1);
      tick(1'b0, 8'd4, 1'b1);
      tick(1'b0, 8'd4, 1'b1);
      tick(1'b1, 8'd4, 1'b1);
      repeat (9) tick(1'b0, 8'd4, 1'b1);
      check_int("retrig_out_1_7",   count_bit(4, b + 1, b + 7), 7);
      check_int("retrig_out_8_12",  count_bit(4, b + 8, b + 12), 0);
      check_int("retrig_done_at_8", count_bit(2, b + 8, b + 8), 1);
      check_int("retrig_done_once", count_bit(2, b + 1, b + 12), 1);

      // Non-retriggerable: trigs in HIGH and GAP ignored, len change mid-pulse
      // ignored, trig in the first IDLE cycle accepted.
      b = t;
      for (int c = 0; c < 14; c++) begin
         tick((c == 0 || c == 3 || c == 5 || c == 6 || c == 7),
              (c == 2) ? 8'd9 : 8'd4, 1'b0);
      end
      check_int("nonretrig_out_1_4",   count_bit(4, b + 1, b + 4), 4);
      check_int("nonretrig_out_5_7",   count_bit(4, b + 5, b + 7), 0);
      check_int("nonretrig_gap_5_6",   count_bit(3, b + 5, b + 6), 2);
      check_int("nonretrig_out_8_11",  count_bit(4, b + 8, b + 11), 4);
      check_int("nonretrig_out_12_13", count_bit(4, b + 12, b + 13), 0);

      // Reset mid-pulse: len=10, rst asserted asynchronously in cycle 4.
      b = t;
      tick(1'b1, 8'd10, 1'b0);
      repeat (3) tick(1'b0, 8'd10, 1'b0);
      check5("pre_rst_high", observed(), 5'b11001);
      #3;
      rst  = 1'b1;
      trig = 1'b1;
      #1;
      check5("async_rst", observed(), 5'b00000);
      @(posedge clk);
      #1;
      t++;
      check5("rst_hold", observed(), 5'b00000);
      rst  = 1'b0;
      trig = 1'b0;
      high_until = -5;
      gap_until  = -5;
      b = t;
      tick(1'b1, 8'd10, 1'b0);
      repeat (14) tick(1'b0, 8'd10, 1'b0);
      check_int("post_rst_out_1_10",  count_bit(4, b + 1, b + 10), 10);
      check_int("post_rst_out_11_14", count_bit(4, b + 11, b + 14), 0);
      check_int("post_rst_done_11",   count_bit(2, b + 11, b + 11), 1);

      // Randomized stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         tick(($urandom_range(0, 3) == 0),
              CNT_W'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
